// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with split-transaction support.
// Optional beat-limit forced release is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int MAX_BEATS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busreq_1,
    input  logic       busreq_2,
    input  logic       last,
    input  logic       ready,
    input  logic       split,
    input  logic       split_release_1,
    input  logic       split_release_2,
    input  logic [1:0] response,
    output logic       grant_1,
    output logic       grant_2,
    output logic       mux_sel,
    output logic       bus_busy,
    output logic [1:0] split_mask,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic       ptr, ptr_nx;
    logic       grant_1_nx, grant_2_nx, mux_sel_nx, bus_busy_nx;
    logic [1:0] split_mask_nx, mask_set, eff_req;
    logic       pick_2, release_bus;

    generate
        if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_max_beats_range
            $error("bus_arbiter: MAX_BEATS must be within 1..255");
        end
    endgenerate

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS);

    logic [7:0] beat_cnt, beat_cnt_nx, beat_inc;
    logic       timeout_nx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign beat_inc = sat_inc(beat_cnt);
`endif

    // A split master is invisible to arbitration until its release arrives.
    assign eff_req = {busreq_2 & ~split_mask[1], busreq_1 & ~split_mask[0]};
    assign pick_2  = (eff_req == 2'b10) || ((eff_req == 2'b11) && ptr);

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        grant_1_nx  = grant_1;
        grant_2_nx  = grant_2;
        mux_sel_nx  = mux_sel;
        bus_busy_nx = bus_busy;
        mask_set    = 2'b00;
        release_bus = 1'b0;
`ifdef ARB_TIMEOUT_EN
        beat_cnt_nx = beat_cnt;
        timeout_nx  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (eff_req != 2'b00) begin
                    state_nx    = GRANT;
                    grant_1_nx  = ~pick_2;
                    grant_2_nx  = pick_2;
                    mux_sel_nx  = pick_2;
                    bus_busy_nx = 1'b1;
                end
            end
            GRANT: state_nx = XFER;
            XFER: begin
                if (ready) begin
                    if (split) begin
                        mask_set    = grant_2 ? 2'b10 : 2'b01;
                        release_bus = 1'b1;
                    end else if (response == 2'b01) begin
                        release_bus = 1'b1;
                    end else if (last) begin
                        release_bus = 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (beat_inc >= BEAT_LIMIT) begin
                        timeout_nx  = 1'b1;
                        release_bus = 1'b1;
                    end else begin
                        beat_cnt_nx = beat_inc;
                    end
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        // mux_sel deliberately keeps pointing at the last owner after release.
        if (release_bus) begin
            state_nx    = IDLE;
            grant_1_nx  = 1'b0;
            grant_2_nx  = 1'b0;
            bus_busy_nx = 1'b0;
            ptr_nx      = grant_1;
`ifdef ARB_TIMEOUT_EN
            beat_cnt_nx = 8'd0;
`endif
        end

        split_mask_nx = (split_mask & ~{split_release_2, split_release_1}) | mask_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            grant_1    <= 1'b0;
            grant_2    <= 1'b0;
            mux_sel    <= 1'b0;
            bus_busy   <= 1'b0;
            split_mask <= 2'b00;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            grant_1    <= grant_1_nx;
            grant_2    <= grant_2_nx;
            mux_sel    <= mux_sel_nx;
            bus_busy   <= bus_busy_nx;
            split_mask <= split_mask_nx;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nx;
            timeout  <= timeout_nx;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic against an ownership-level reference model.
module tb_bus_arbiter;

    localparam int MAXB = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk, rst;
    logic       busreq_1, busreq_2, last, ready, split;
    logic       split_release_1, split_release_2;
    logic [1:0] response;
    logic       grant_1, grant_2, mux_sel, bus_busy, timeout;
    logic [1:0] split_mask;
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .busreq_1(busreq_1), .busreq_2(busreq_2),
        .last(last), .ready(ready), .split(split),
        .split_release_1(split_release_1), .split_release_2(split_release_2),
        .response(response),
        .grant_1(grant_1), .grant_2(grant_2), .mux_sel(mux_sel),
        .bus_busy(bus_busy), .split_mask(split_mask), .timeout(timeout)
    );

    // {grant_1, grant_2, mux_sel, bus_busy, split_mask[1:0], timeout}
    assign outs = {grant_1, grant_2, mux_sel, bus_busy, split_mask, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        busreq_1 = 0; busreq_2 = 0; last = 0; ready = 0; split = 0;
        split_release_1 = 0; split_release_2 = 0; response = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        busreq_1 = 1; busreq_2 = 1; ready = 1;
        rst = 1;
        tick();
        tick();
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_values: got %b want %b", outs, 7'b0000000);
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_single_master();
        logic [6:0] exp_seq [5];
        exp_seq = '{7'b1001000, 7'b1001000, 7'b1001000, 7'b1001000, 7'b0000000};
        do_reset();
        busreq_1 = 1;
        for (int i = 0; i < 5; i++) begin
            ready = (i >= 1);
            last  = (i == 4);
            tick();
            total++;
            if (outs !== exp_seq[i]) begin
                bad++;
                $display("FAIL single_master step %0d: got %b want %b", i, outs, exp_seq[i]);
            end
        end
        // ptr now favours master 2
        ready = 0; last = 0; busreq_1 = 1; busreq_2 = 1;
        tick();
        total++;
        if (outs !== 7'b0111000) begin
            bad++;
            $display("FAIL ptr_after_release: got %b want %b", outs, 7'b0111000);
        end
        tick();
        ready = 1; last = 1;
        tick();
        total++;
        if (outs !== 7'b0010000) begin
            bad++;
            $display("FAIL release_keeps_mux: got %b want %b", outs, 7'b0010000);
        end
        clear_inputs();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g   [12];
        logic       exp_mux [12];
        exp_g   = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                    2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        exp_mux = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        do_reset();
        busreq_1 = 1; busreq_2 = 1; ready = 1; last = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if ({grant_1, grant_2, mux_sel, bus_busy} !==
                {exp_g[i], exp_mux[i], |exp_g[i]}) begin
                bad++;
                $display("FAIL alternate cycle %0d: got g=%b%b mux=%b busy=%b want g=%b mux=%b busy=%b",
                         i, grant_1, grant_2, mux_sel, bus_busy, exp_g[i], exp_mux[i], |exp_g[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_split();
        do_reset();
        busreq_2 = 1;
        tick();
        total++;
        if (outs !== 7'b0111000) begin
            bad++;
            $display("FAIL split_grant2: got %b want %b", outs, 7'b0111000);
        end
        tick();
        ready = 1; split = 1;
        tick();
        total++;
        if (outs !== 7'b0010100) begin
            bad++;
            $display("FAIL split_release: got %b want %b", outs, 7'b0010100);
        end
        split = 0; ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== 7'b0010100) begin
                bad++;
                $display("FAIL split_masked wait %0d: got %b want %b", i, outs, 7'b0010100);
            end
        end
        split_release_2 = 1;
        tick();
        total++;
        if (outs !== 7'b0010000) begin
            bad++;
            $display("FAIL split_unmask: got %b want %b", outs, 7'b0010000);
        end
        split_release_2 = 0;
        tick();
        total++;
        if (outs !== 7'b0111000) begin
            bad++;
            $display("FAIL split_regrant: got %b want %b", outs, 7'b0111000);
        end
        tick();
        ready = 1; split = 1; split_release_2 = 1;
        tick();
        total++;
        if (outs !== 7'b0010100) begin
            bad++;
            $display("FAIL split_set_wins: got %b want %b", outs, 7'b0010100);
        end
        clear_inputs();
    endtask

    task automatic test_error();
        do_reset();
        busreq_1 = 1;
        tick();
        busreq_1 = 0;
        tick();
        ready = 1; response = 2'b00;
        tick();
        total++;
        if (outs !== 7'b1001000) begin
            bad++;
            $display("FAIL error_beat1_held: got %b want %b", outs, 7'b1001000);
        end
        response = 2'b01;
        tick();
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL error_release: got %b want %b", outs, 7'b0000000);
        end
        clear_inputs();
        tick();
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL error_no_timeout: got %b want %b", outs, 7'b0000000);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        busreq_1 = 1;
        tick();
        busreq_1 = 0;
        tick();
        ready = 1; last = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < MAXB; i++) begin
            tick();
            total++;
            if (outs !== 7'b1001000) begin
                bad++;
                $display("FAIL timeout_hold beat %0d: got %b want %b", i, outs, 7'b1001000);
            end
        end
        tick();
        total++;
        if (outs !== 7'b0000001) begin
            bad++;
            $display("FAIL timeout_pulse: got %b want %b", outs, 7'b0000001);
        end
        tick();
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL timeout_one_cycle: got %b want %b", outs, 7'b0000000);
        end
`else
        for (int i = 1; i <= 22; i++) begin
            tick();
            total++;
            if (outs !== 7'b1001000) begin
                bad++;
                $display("FAIL no_timeout_hold beat %0d: got %b want %b", i, outs, 7'b1001000);
            end
        end
        last = 1;
        tick();
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL no_timeout_last: got %b want %b", outs, 7'b0000000);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        busreq_1 = 1;
        tick();
        busreq_1 = 0;
        tick();
        ready = 1; split = 1;
        tick();
        split = 0; ready = 0; busreq_2 = 1;
        tick();
        tick();
        total++;
        if (outs !== 7'b0111010) begin
            bad++;
            $display("FAIL async_pre_xfer: got %b want %b", outs, 7'b0111010);
        end
        #2;
        rst = 1;
        #1;
        total++;
        if (outs !== 7'b0000000) begin
            bad++;
            $display("FAIL async_reset_immediate: got %b want %b", outs, 7'b0000000);
        end
        @(negedge clk);
        clear_inputs();
        rst = 0;
    endtask

    task automatic test_random();
        int         m_owner, m_pref, m_beats, r;
        bit         m_addr, m_mux, m_to, e1, e2, done;
        logic [1:0] m_mask, new_mask;
        logic [6:0] expv;
        do_reset();
        m_owner = 0; m_pref = 1; m_beats = 0;
        m_addr = 0; m_mux = 0; m_to = 0; m_mask = 2'b00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            busreq_1 = ($urandom_range(0, 3) != 0);
            busreq_2 = ($urandom_range(0, 3) != 0);
            ready    = ($urandom_range(0, 9) < 7);
            last     = ($urandom_range(0, 3) == 0);
            split    = ($urandom_range(0, 19) == 0);
            split_release_1 = ($urandom_range(0, 7) == 0);
            split_release_2 = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 15);
            response = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;

            new_mask = m_mask & ~{split_release_2, split_release_1};
            m_to = 0;
            if (m_owner == 0) begin
                e1 = busreq_1 && !m_mask[0];
                e2 = busreq_2 && !m_mask[1];
                if (e1 && e2)  m_owner = m_pref;
                else if (e1)   m_owner = 1;
                else if (e2)   m_owner = 2;
                if (m_owner != 0) begin
                    m_addr = 1;
                    m_mux  = (m_owner == 2);
                end
            end else if (m_addr) begin
                m_addr = 0;
            end else if (ready) begin
                m_beats++;
                done = 0;
                if (split) begin
                    new_mask[m_owner-1] = 1'b1;
                    done = 1;
                end else if (response == 2'b01) done = 1;
                else if (last) done = 1;
                else if (TO_EN && m_beats >= MAXB) begin
                    done = 1;
                    m_to = 1;
                end
                if (done) begin
                    m_pref  = (m_owner == 1) ? 2 : 1;
                    m_owner = 0;
                    m_beats = 0;
                end
            end
            m_mask = new_mask;
            expv = {m_owner == 1, m_owner == 2, m_mux, m_owner != 0, m_mask, m_to};

            tick();
            total++;
            if (outs !== expv) begin
                bad++;
                $display("FAIL random cycle %0d: got %b want %b", cyc, outs, expv);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_master();
        test_alternate();
        test_split();
        test_error();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master round-robin bus arbiter with split-transaction support. Samples `busreq_1`/`busreq_2` and issues one-hot `grant_1`/`grant_2` plus the master-side mux select. Holds ownership until the slave completes, splits or errors the transfer. Sits ahead of the bus state controller, which consumes the grants and drives the slave-side selects.

## Interface
- `MAX_BEATS`, default 8: completed beats after which ownership is forcibly released (only with `ARB_TIMEOUT_EN`); legal range 1–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `busreq_1`, `busreq_2` in 1: master bus requests, level-sensitive.
- `last` in 1: owning master marks the current beat as final.
- `ready` in 1: slave ready; a beat completes in XFER when `ready`=1.
- `split` in 1: slave splits the current owner's transaction; qualified by `ready`=1.
- `split_release_1`, `split_release_2` in 1: slave re-enables a split master.
- `response` in 2: `00` OKAY, `01` ERROR, others treated as OKAY; qualified by `ready`=1.
- `grant_1`, `grant_2` out 1: registered, one-hot or zero.
- `mux_sel` out 1: 0 = master 1 drives the bus, 1 = master 2.
- `bus_busy` out 1: high in GRANT and XFER.
- `split_mask` out 2: bit0 = master 1 masked, bit1 = master 2 masked.
- `timeout` out 1: one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, XFER. State and priority pointer `ptr` are encoded internally (`ptr` 0 = master 1 first).
- Effective request for master i = `busreq_i` & ~`split_mask[i]`.
- **IDLE:**
  - No effective request: stay in IDLE.
  - One effective request: grant that master.
  - Both requesting: grant master `ptr`.
  - On grant: go to GRANT, set the granted `grant_x`, and set `mux_sel`.
- **GRANT:** one address cycle, then unconditionally go to XFER. Grant and `mux_sel` are held.
- **XFER:** evaluated only when `ready`=1, in this priority order:
  1. `split`: set the owner's mask bit, release, go to IDLE.
  2. `response`=`01`: release, go to IDLE.
  3. `last`: release, go to IDLE.
  4. Beat count reaches `MAX_BEATS` (macro on): pulse `timeout`, release, go to IDLE.
  5. Otherwise: increment the beat counter and stay in XFER.
- `ready`=0: stay in XFER with no counting.
- Release actions: clear both grants and `bus_busy`; set `ptr` to the non-owner; clear the beat counter. `mux_sel` keeps its last value.
- Requests dropped during GRANT/XFER are ignored; ownership ends only by the rules above.
- `split_release_i` clears `split_mask[i]`. If a split sets the same bit in the same cycle, the set wins.
- Both masters masked: remain in IDLE, outputs at idle values.
- Beat counter is 8 bits, saturating, reset to 0. It counts completed beats, including the terminating beat.

## Timing
- Reset values (asynchronous): state IDLE, `ptr`=0, `grant_1`=`grant_2`=0, `mux_sel`=0, `bus_busy`=0, `split_mask`=00, `timeout`=0, beat counter 0.
- Request to grant: a request sampled at edge N (IDLE) gives grant high after edge N. GRANT covers cycle N+1; XFER starts at edge N+1.
- Minimum ownership: 2 cycles (GRANT plus one XFER beat with `ready`=1).
- Release: the grant falls at the edge that samples the terminating beat. A new grant needs at least one IDLE cycle, so there is one dead cycle between owners.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). The in-flight transfer is abandoned with no `timeout` pulse.
- `timeout` is high for exactly the cycle after the forcing edge.

## Configuration
- `ARB_TIMEOUT_EN` defined: beat limit is active, and rule 4 and the `timeout` pulse are implemented.
- `ARB_TIMEOUT_EN` undefined:
  - Transfers end only on `split`, ERROR, or `last`.
  - `timeout` is tied to 0.
  - The beat counter is removed.
  - `MAX_BEATS` is ignored.

## Test plan
- Reset, then `busreq_1`=1 only → `grant_1`=1 one cycle later, `mux_sel`=0. Three beats with `last` on the third → grant drops after the third ready beat; `ptr`=1.
- Both requests held continuously, 1-beat transfers → grants alternate 1, 2, 1, 2 with one idle cycle between owners.
- Master 2 owns; `split`=1 with `ready`=1 → `split_mask`=10, grant released. Master 2 stays ungranted while requesting until `split_release_2`, then is granted again.
- `response`=`01` with `ready`=1 on beat 2 of master 1 → release at that edge; `timeout`=0.
- With `ARB_TIMEOUT_EN`, `MAX_BEATS`=4, `last` never asserted → release after the 4th ready beat, `timeout` pulses once. Without the macro, grant is held past 20 beats.
- `rst` asserted in XFER while `grant_2`=1 → all outputs 0 and `split_mask`=00 without waiting for a clock edge.
